// File: rtl/answer_check.sv
// answer_check: answer phase of a round. Latches the special-symbol count on
// answerSig, runs a timed entry window where the player steps a guess and
// submits it, scores the guess and holds the result before returning to idle.
//
// Ports:
//   Clk100M, RstN           clock, asynchronous active-low reset
//   answerSig, numSpecial   round-end pulse and target count sampled with it
//   secTick                 one-cycle pulse per second
//   incBtn/decBtn/submitBtn debounced one-cycle button pulses
//   guess, secLeft          current guess and remaining entry seconds
//   answerActive            high in ENTRY
//   resultValid             high in RESULT
//   correct, timedOut       result flags, valid in RESULT
//   doneP                   one-cycle pulse on entering RESULT
//   score, rounds           correct rounds (saturating), completed rounds (wrapping)
module answer_check #(
  parameter int unsigned ANSWER_SECS = 10,
  parameter int unsigned RESULT_SECS = 3,
  parameter int unsigned MAX_GUESS   = 99
) (
  input  logic       Clk100M,
  input  logic       RstN,
  input  logic       answerSig,
  input  logic [7:0] numSpecial,
  input  logic       secTick,
  input  logic       incBtn,
  input  logic       decBtn,
  input  logic       submitBtn,
  output logic [7:0] guess,
  output logic [7:0] secLeft,
  output logic       answerActive,
  output logic       resultValid,
  output logic       correct,
  output logic       timedOut,
  output logic       doneP,
  output logic [7:0] score,
  output logic [7:0] rounds
);

  localparam logic [7:0] MAXG   = 8'(MAX_GUESS);
  localparam logic [7:0] ASECS  = 8'(ANSWER_SECS);
  localparam logic [7:0] RSECS  = 8'(RESULT_SECS);

  typedef enum logic [1:0] {IDLE, ENTRY, RESULT} state_t;

  state_t     state, state_n;
  logic [7:0] target, target_n;
  logic [7:0] hold, hold_n;
  logic [7:0] guess_n, secLeft_n, score_n, rounds_n;
  logic       answerActive_n, resultValid_n, correct_n, timedOut_n, doneP_n;
  logic       enterResult, startEntry;

  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      state        <= IDLE;
      target       <= '0;
      hold         <= '0;
      guess        <= '0;
      secLeft      <= '0;
      answerActive <= 1'b0;
      resultValid  <= 1'b0;
      correct      <= 1'b0;
      timedOut     <= 1'b0;
      doneP        <= 1'b0;
      score        <= '0;
      rounds       <= '0;
    end else begin
      state        <= state_n;
      target       <= target_n;
      hold         <= hold_n;
      guess        <= guess_n;
      secLeft      <= secLeft_n;
      answerActive <= answerActive_n;
      resultValid  <= resultValid_n;
      correct      <= correct_n;
      timedOut     <= timedOut_n;
      doneP        <= doneP_n;
      score        <= score_n;
      rounds       <= rounds_n;
    end
  end

  always_comb begin
    state_n        = state;
    target_n       = target;
    hold_n         = hold;
    guess_n        = guess;
    secLeft_n      = secLeft;
    answerActive_n = answerActive;
    resultValid_n  = resultValid;
    correct_n      = correct;
    timedOut_n     = timedOut;
    doneP_n        = 1'b0;
    score_n        = score;
    rounds_n       = rounds;
    enterResult    = 1'b0;
    startEntry     = 1'b0;

    case (state)
      IDLE: begin
        if (answerSig) startEntry = 1'b1;
      end
      ENTRY: begin
        // Submit compares the pre-update guess; any same-cycle inc/dec is dropped.
        if (submitBtn) begin
          correct_n   = (guess == target);
          timedOut_n  = 1'b0;
          enterResult = 1'b1;
        end else if (secTick && secLeft == 8'd1) begin
          secLeft_n   = '0;
          correct_n   = 1'b0;
          timedOut_n  = 1'b1;
          enterResult = 1'b1;
        end else begin
          if (secTick && secLeft > 8'd1) secLeft_n = secLeft - 8'd1;
          if (incBtn && !decBtn && guess < MAXG)
            guess_n = guess + 8'd1;
          else if (decBtn && !incBtn && guess != 8'd0)
            guess_n = guess - 8'd1;
        end
      end
      RESULT: begin
        if (answerSig) begin
          startEntry = 1'b1;
        end else if (submitBtn || (secTick && hold <= 8'd1)) begin
          state_n       = IDLE;
          resultValid_n = 1'b0;
          correct_n     = 1'b0;
          timedOut_n    = 1'b0;
          guess_n       = '0;
          secLeft_n     = '0;
          hold_n        = '0;
        end else if (secTick) begin
          hold_n = hold - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (startEntry) begin
      state_n        = ENTRY;
      target_n       = numSpecial;
      guess_n        = '0;
      secLeft_n      = ASECS;
      answerActive_n = 1'b1;
      resultValid_n  = 1'b0;
      correct_n      = 1'b0;
      timedOut_n     = 1'b0;
    end

    if (enterResult) begin
      state_n        = RESULT;
      doneP_n        = 1'b1;
      rounds_n       = rounds + 8'd1;
      if (correct_n && score != 8'hFF) score_n = score + 8'd1;
      hold_n         = RSECS;
      answerActive_n = 1'b0;
      resultValid_n  = 1'b1;
    end
  end

endmodule

// File: tb/tb_answer_check.sv
// tb_answer_check: directed-vector bench for answer_check with default
// parameters (10 s entry window, 3 s result hold, guess limit 99).
module tb_answer_check;

  logic       Clk100M = 1'b0;
  logic       RstN = 1'b0;
  logic       answerSig = 1'b0;
  logic [7:0] numSpecial = '0;
  logic       secTick = 1'b0;
  logic       incBtn = 1'b0;
  logic       decBtn = 1'b0;
  logic       submitBtn = 1'b0;
  logic [7:0] guess, secLeft, score, rounds;
  logic       answerActive, resultValid, correct, timedOut, doneP;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  answer_check #(.ANSWER_SECS(10), .RESULT_SECS(3), .MAX_GUESS(99)) dut (
    .Clk100M(Clk100M), .RstN(RstN), .answerSig(answerSig), .numSpecial(numSpecial),
    .secTick(secTick), .incBtn(incBtn), .decBtn(decBtn), .submitBtn(submitBtn),
    .guess(guess), .secLeft(secLeft), .answerActive(answerActive),
    .resultValid(resultValid), .correct(correct), .timedOut(timedOut),
    .doneP(doneP), .score(score), .rounds(rounds)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic start_round(input logic [7:0] n);
    answerSig = 1'b1; numSpecial = n; cyc(); answerSig = 1'b0;
  endtask
  task automatic inc_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin incBtn = 1'b1; cyc(); incBtn = 1'b0; cyc(); end
  endtask
  task automatic dec_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin decBtn = 1'b1; cyc(); decBtn = 1'b0; end
  endtask
  task automatic tick();
    secTick = 1'b1; cyc(); secTick = 1'b0;
  endtask
  task automatic submit();
    submitBtn = 1'b1; cyc(); submitBtn = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".guess"}, guess, 0);
    check_eq({tag, ".secLeft"}, secLeft, 0);
    check_eq({tag, ".flags"}, {answerActive, resultValid, correct, timedOut, doneP}, 0);
    check_eq({tag, ".score"}, score, 0);
    check_eq({tag, ".rounds"}, rounds, 0);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    check_all_zero("rst");
    RstN = 1'b1; cyc();

    // Asynchronous reset mid-ENTRY
    start_round(8'd3);
    inc_n(5);
    check_eq("pre_rst_guess", guess, 5);
    check_eq("pre_rst_active", answerActive, 1);
    #2 RstN = 1'b0; #1;
    check_all_zero("async_rst");
    cyc(); RstN = 1'b1; cyc();
    inc_n(3);
    check_eq("idle_inc_guess", guess, 0);
    check_eq("idle_active", answerActive, 0);

    // Correct answer
    start_round(8'd3);
    check_eq("c_active", answerActive, 1);
    check_eq("c_secleft", secLeft, 10);
    check_eq("c_guess0", guess, 0);
    inc_n(3);
    check_eq("c_guess3", guess, 3);
    submit();
    check_eq("c_doneP", doneP, 1);
    check_eq("c_valid", resultValid, 1);
    check_eq("c_correct", correct, 1);
    check_eq("c_timedout", timedOut, 0);
    check_eq("c_score", score, 1);
    check_eq("c_rounds", rounds, 1);
    check_eq("c_active0", answerActive, 0);
    cyc();
    check_eq("c_doneP_off", doneP, 0);
    check_eq("c_guess_held", guess, 3);
    tick(); tick();
    check_eq("c_hold_valid", resultValid, 1);
    check_eq("c_hold_correct", correct, 1);
    tick();
    check_eq("c_idle_valid", resultValid, 0);
    check_eq("c_idle_correct", correct, 0);
    check_eq("c_idle_guess", guess, 0);

    // Saturation
    start_round(8'd50);
    inc_n(105);
    check_eq("sat_hi", guess, 99);
    dec_n(120);
    check_eq("sat_lo", guess, 0);
    inc_n(4);
    incBtn = 1'b1; decBtn = 1'b1; cyc(); incBtn = 1'b0; decBtn = 1'b0;
    check_eq("incdec_same", guess, 4);
    submit();
    check_eq("sat_correct", correct, 0);
    check_eq("sat_score", score, 1);
    check_eq("sat_rounds", rounds, 2);
    submit();
    check_eq("sat_dismiss", resultValid, 0);

    // Timeout: secLeft steps 10 down to 0
    start_round(8'd2);
    for (int unsigned i = 1; i <= 10; i++) begin
      tick();
      check_eq($sformatf("to_secleft%0d", i), secLeft, 10 - i);
    end
    check_eq("to_doneP", doneP, 1);
    check_eq("to_timedout", timedOut, 1);
    check_eq("to_correct", correct, 0);
    check_eq("to_score", score, 1);
    check_eq("to_rounds", rounds, 3);
    submit();
    check_eq("to_dismiss", {resultValid, timedOut}, 0);

    // Submit on the expiring tick wins
    start_round(8'd2);
    inc_n(2);
    for (int unsigned i = 0; i < 9; i++) tick();
    check_eq("sim_secleft1", secLeft, 1);
    submitBtn = 1'b1; secTick = 1'b1; cyc(); submitBtn = 1'b0; secTick = 1'b0;
    check_eq("sim_correct", correct, 1);
    check_eq("sim_timedout", timedOut, 0);
    check_eq("sim_score", score, 2);
    check_eq("sim_rounds", rounds, 4);
    submit();

    // inc with submit uses the pre-increment guess
    start_round(8'd1);
    inc_n(1);
    incBtn = 1'b1; submitBtn = 1'b1; cyc(); incBtn = 1'b0; submitBtn = 1'b0;
    check_eq("incsub_correct", correct, 1);
    check_eq("incsub_guess", guess, 1);
    check_eq("incsub_score", score, 3);

    // Restart from RESULT, then answerSig ignored in ENTRY
    start_round(8'd7);
    check_eq("rs_active", answerActive, 1);
    check_eq("rs_valid", resultValid, 0);
    check_eq("rs_correct", correct, 0);
    check_eq("rs_guess", guess, 0);
    check_eq("rs_secleft", secLeft, 10);
    tick(); tick();
    start_round(8'd9);
    check_eq("rs_ignored_secleft", secLeft, 8);
    check_eq("rs_ignored_active", answerActive, 1);
    inc_n(7);
    submit();
    check_eq("rs_target7", correct, 1);
    check_eq("rs_score", score, 4);
    check_eq("rs_rounds", rounds, 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
